// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slave-port signal bundle between the interconnect and one SRAM slave.
// HREADY is the bus-level ready returned by the read-data/response mux.
interface ahb_lite_sram_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADY, HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte/halfword/word writes,
// WAIT_STATES extra data-phase cycles per OKAY transfer and a two-cycle ERROR
// response for illegal size, misaligned or out-of-range accesses.
// Only DATA_WIDTH = 32 is supported; MEM_WORDS must be a power of two (>= 2).
module ahb_lite_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 1
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int          IDX_W      = $clog2(MEM_WORDS);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            lane_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  accept;
  logic                  addr_err;
  logic                  capture;
  logic [3:0]            strobe;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
  logic unused_htrans_lsb;
  assign unused_htrans_lsb = bus.HTRANS[0];

  // A transfer is taken only for a selected, ready, NONSEQ/SEQ address phase.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  // Classify the address phase being offered as legal or erroring.
  always_comb begin
    addr_err = 1'b0;
    if (bus.HSIZE > 3'b010)
      addr_err = 1'b1;
    if ((bus.HSIZE == 3'b001) && bus.HADDR[0])
      addr_err = 1'b1;
    if ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00))
      addr_err = 1'b1;
    if (bus.HADDR[31:2] >= WORD_LIMIT)
      addr_err = 1'b1;
  end

  // Next-state logic: IDLE, LAST and ERR2 are the cycles that can take a new transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1)
          state_d = ST_LAST;
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          capture = 1'b1;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_INIT == 4'd0) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
    endcase
  end

  // State register, wait counter and address-phase capture with synchronous reset.
  always_ff @(posedge HCLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // independent of the order of statements or processes.
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= bus.HADDR[IDX_W+1:2];
        lane_q  <= bus.HADDR[1:0];
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE;
      end
    end
  end

  // Byte-lane write strobes from the captured size and low address bits.
  always_comb begin
    strobe = 4'b0000;
    case (size_q)
      3'b000:  strobe = 4'b0001 << lane_q;
      3'b001:  strobe = lane_q[1] ? 4'b1100 : 4'b0011;
      3'b010:  strobe = 4'b1111;
      default: strobe = 4'b0000;
    endcase
  end

  // Memory write at the end of the final data-phase cycle of a legal write.
  always_ff @(posedge HCLK) begin
    // NOTE: the array is deliberately left out of reset; only the control path
    // is reset, which keeps this a plain RAM. The reset term here only blocks a
    // write whose final cycle coincides with reset.
    if (HRESETn && (state_q == ST_LAST) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe[b])
          mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  // Response outputs decoded from the current state; read data only in LAST.
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;
    case (state_q)
      ST_WAIT: bus.HREADYOUT = 1'b0;
      ST_LAST: if (!write_q) bus.HRDATA = mem[idx_q];
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
      end
      ST_ERR2: bus.HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed testbench for ahb_lite_sram_slave: one instance with one wait state
// driven by single transfers, one with zero wait states driven back-to-back.
// Each slave's HREADYOUT is looped back as its HREADY (single-slave mux).
module tb_ahb_lite_sram_slave;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [2:0] SZ_BYTE   = 3'b000;
  localparam logic [2:0] SZ_HALF   = 3'b001;
  localparam logic [2:0] SZ_WORD   = 3'b010;

  logic HCLK = 1'b0;
  logic HRESETn;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave_if #(.DATA_WIDTH(32)) bus1 ();
  ahb_lite_sram_slave_if #(.DATA_WIDTH(32)) bus0 ();

  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus0.HREADY = bus0.HREADYOUT;

  ahb_lite_sram_slave #(.DATA_WIDTH(32), .MEM_WORDS(256), .WAIT_STATES(1)) dut_ws1 (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus1.slave)
  );

  ahb_lite_sram_slave #(.DATA_WIDTH(32), .MEM_WORDS(256), .WAIT_STATES(0)) dut_ws0 (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus0.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer on the one-wait-state slave. Called at a negedge
  // with the slave idle; returns at a negedge with the slave idle again.
  task automatic xfer1(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output int lows, output logic resp_first,
                       output logic resp_last, output logic [31:0] rdata);
    bit done;
    done       = 1'b0;
    lows       = 0;
    resp_last  = 1'b0;
    rdata      = '0;
    bus1.HSEL   = 1'b1;
    bus1.HTRANS = HT_NONSEQ;
    bus1.HADDR  = addr;
    bus1.HWRITE = wr;
    bus1.HSIZE  = size;
    @(negedge HCLK);
    bus1.HSEL   = 1'b0;
    bus1.HTRANS = HT_IDLE;
    bus1.HWDATA = wdata;
    resp_first  = bus1.HRESP;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus1.HREADYOUT) begin
        done      = 1'b1;
        resp_last = bus1.HRESP;
        rdata     = bus1.HRDATA;
      end else begin
        lows++;
        @(negedge HCLK);
      end
    end
    check("xfer_done", 32'(done), 32'd1);
    @(negedge HCLK);
  endtask

  task automatic write1(input string tag, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
    int          lows;
    logic        rf, rl;
    logic [31:0] rd;
    xfer1(1'b1, addr, size, wdata, lows, rf, rl, rd);
    check({tag, "_wait_cycles"}, 32'(lows), 32'd1);
    check({tag, "_resp"}, 32'({rf, rl}), 32'd0);
    check({tag, "_rdata_zero"}, rd, 32'h0);
  endtask

  task automatic read1(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int          lows;
    logic        rf, rl;
    logic [31:0] rd;
    xfer1(1'b0, addr, SZ_WORD, 32'h0, lows, rf, rl, rd);
    check({tag, "_wait_cycles"}, 32'(lows), 32'd1);
    check({tag, "_resp"}, 32'({rf, rl}), 32'd0);
    check({tag, "_rdata"}, rd, exp);
  endtask

  // Expect ERR1 (ready low, ERROR) then ERR2 (ready high, ERROR).
  task automatic error1(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size);
    int          lows;
    logic        rf, rl;
    logic [31:0] rd;
    xfer1(wr, addr, size, 32'h1234_5678, lows, rf, rl, rd);
    check({tag, "_err1_low_cycles"}, 32'(lows), 32'd1);
    check({tag, "_err1_resp"}, 32'(rf), 32'd1);
    check({tag, "_err2_resp"}, 32'(rl), 32'd1);
  endtask

  // Back-to-back beats for the zero-wait slave; p_exp is HRDATA in each data phase.
  logic        p_wr   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] p_addr [6] = '{32'h00, 32'h04, 32'h00, 32'h04, 32'h08, 32'h08};
  logic [31:0] p_data [6] = '{32'h1357_9BDF, 32'h2468_ACE0, 32'h0, 32'h0, 32'hA5A5_5A5A, 32'h0};
  logic [31:0] p_exp  [6] = '{32'h0, 32'h0, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0, 32'hA5A5_5A5A};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus1.HSEL = 1'b0; bus1.HTRANS = HT_IDLE; bus1.HADDR = '0; bus1.HWRITE = 1'b0;
    bus1.HSIZE = SZ_WORD; bus1.HWDATA = '0;
    bus0.HSEL = 1'b0; bus0.HTRANS = HT_IDLE; bus0.HADDR = '0; bus0.HWRITE = 1'b0;
    bus0.HSIZE = SZ_WORD; bus0.HWDATA = '0;
    HRESETn = 1'b0;

    // 1. Reset for two rising edges, then idle/busy cycles stay zero-wait OKAY.
    @(negedge HCLK);
    @(negedge HCLK);
    check("rst_hreadyout", 32'(bus1.HREADYOUT), 32'd1);
    check("rst_hresp", 32'(bus1.HRESP), 32'd0);
    check("rst_hrdata", bus1.HRDATA, 32'h0);
    check("rst_ws0_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    HRESETn = 1'b1;
    bus1.HSEL = 1'b1; bus1.HTRANS = HT_IDLE; bus1.HADDR = 32'h10;
    @(negedge HCLK);
    check("idle_hreadyout", 32'(bus1.HREADYOUT), 32'd1);
    check("idle_hresp", 32'(bus1.HRESP), 32'd0);
    bus1.HTRANS = HT_BUSY;
    @(negedge HCLK);
    check("busy_hreadyout", 32'(bus1.HREADYOUT), 32'd1);
    check("busy_hresp", 32'(bus1.HRESP), 32'd0);
    bus1.HSEL = 1'b0; bus1.HTRANS = HT_IDLE;
    @(negedge HCLK);

    // 2. Word write then read with one wait state.
    write1("t2_wr", 32'h10, SZ_WORD, 32'hDEAD_BEEF);
    read1("t2_rd", 32'h10, 32'hDEAD_BEEF);

    // 3. Sub-word writes only touch their lanes (other HWDATA lanes are garbage).
    write1("t3_wr_word", 32'h10, SZ_WORD, 32'h1122_3344);
    write1("t3_wr_byte3", 32'h13, SZ_BYTE, 32'hAA55_6677);
    read1("t3_rd_byte3", 32'h10, 32'hAA22_3344);
    write1("t3_wr_word14", 32'h14, SZ_WORD, 32'h0102_0304);
    write1("t3_wr_half_hi", 32'h16, SZ_HALF, 32'h5566_9999);
    read1("t3_rd_half_hi", 32'h14, 32'h5566_0304);
    write1("t3_wr_byte0", 32'h14, SZ_BYTE, 32'h7777_77EE);
    read1("t3_rd_byte0", 32'h14, 32'h5566_03EE);

    // 4. Erroring writes never reach memory.
    write1("t4_wr_base", 32'h00, SZ_WORD, 32'hCAFE_F00D);
    error1("t4_half_misaligned", 1'b1, 32'h01, SZ_HALF);
    error1("t4_word_misaligned", 1'b1, 32'h02, SZ_WORD);
    error1("t4_bad_size", 1'b1, 32'h00, 3'b011);
    read1("t4_rd_unchanged", 32'h00, 32'hCAFE_F00D);

    // 5. Word index MEM_WORDS errors; the last word is legal.
    error1("t5_rd_out_of_range", 1'b0, 32'h400, SZ_WORD);
    write1("t5_wr_top", 32'h3FC, SZ_WORD, 32'h0F0F_0F0F);
    read1("t5_rd_top", 32'h3FC, 32'h0F0F_0F0F);

    // 6. Reset during the wait state of a write aborts it.
    write1("t6_wr_old", 32'h20, SZ_WORD, 32'h0BAD_F00D);
    bus1.HSEL = 1'b1; bus1.HTRANS = HT_NONSEQ; bus1.HADDR = 32'h20;
    bus1.HWRITE = 1'b1; bus1.HSIZE = SZ_WORD;
    @(negedge HCLK);
    check("t6_in_wait", 32'(bus1.HREADYOUT), 32'd0);
    bus1.HSEL = 1'b0; bus1.HTRANS = HT_IDLE; bus1.HWDATA = 32'hFFFF_FFFF;
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("t6_rst_hreadyout", 32'(bus1.HREADYOUT), 32'd1);
    check("t6_rst_hresp", 32'(bus1.HRESP), 32'd0);
    check("t6_rst_hrdata", bus1.HRDATA, 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    read1("t6_rd_old", 32'h20, 32'h0BAD_F00D);

    // 5b. Zero wait states: pipelined NONSEQ beats complete one per cycle.
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        check($sformatf("p%0d_hreadyout", i - 1), 32'(bus0.HREADYOUT), 32'd1);
        check($sformatf("p%0d_hrdata", i - 1), bus0.HRDATA, p_exp[i-1]);
        bus0.HWDATA = p_data[i-1];
      end
      if (i < 6) begin
        bus0.HSEL   = 1'b1;
        bus0.HTRANS = HT_NONSEQ;
        bus0.HADDR  = p_addr[i];
        bus0.HWRITE = p_wr[i];
        bus0.HSIZE  = SZ_WORD;
      end else begin
        bus0.HSEL   = 1'b0;
        bus0.HTRANS = HT_IDLE;
      end
      @(negedge HCLK);
    end

    // Error on the zero-wait slave still takes exactly two cycles.
    bus0.HSEL = 1'b1; bus0.HTRANS = HT_NONSEQ; bus0.HADDR = 32'h400; bus0.HWRITE = 1'b0;
    @(negedge HCLK);
    bus0.HSEL = 1'b0; bus0.HTRANS = HT_IDLE;
    check("ws0_err1", 32'({bus0.HREADYOUT, bus0.HRESP}), 32'b01);
    @(negedge HCLK);
    check("ws0_err2", 32'({bus0.HREADYOUT, bus0.HRESP}), 32'b11);
    @(negedge HCLK);
    check("ws0_after_err", 32'({bus0.HREADYOUT, bus0.HRESP}), 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
